// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_if
// Brief    : Request/response bundle between the W stage, source B and the RF
//            write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [31:0] rf_pc;
  logic [31:0] pend_mask;
  logic        a_stall;
  logic [2:0]  b_count;

  modport master (
    output a_we, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
    input  b_ready, rf_we, rf_a3, rf_wd, rf_pc, pend_mask, a_stall, b_count
  );

  modport slave (
    input  a_we, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
    output b_ready, rf_we, rf_a3, rf_wd, rf_pc, pend_mask, a_stall, b_count
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the RF write port between the W stage (always wins) and a
//            buffered long-latency source B with supersede and anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

  logic [4:0]            r_addr [DEPTH];
  logic [31:0]           r_data [DEPTH];
  logic [31:0]           r_pc   [DEPTH];
  logic [2:0]            r_count;
  logic [c_STARVE_W-1:0] r_starve;
  logic                  r_stall;
  logic                  r_rf_we;
  logic [4:0]            r_rf_a3;
  logic [31:0]           r_rf_wd;
  logic [31:0]           r_rf_pc;

  logic [4:0]            w_addr [DEPTH];
  logic [31:0]           w_data [DEPTH];
  logic [31:0]           w_pc   [DEPTH];
  logic [DEPTH-1:0]      w_keep;
  logic [2:0]            w_kept;
  logic [2:0]            w_cnt;
  logic [2:0]            w_count;
  logic [c_STARVE_W-1:0] w_starve;
  logic [31:0]           w_pend;
  logic                  w_a_act;
  logic                  w_b_ready;
  logic                  w_push;
  logic                  w_pop;

  assign w_a_act   = bus.a_we && (bus.a_addr != 5'd0);
  assign w_b_ready = (r_count < 3'(DEPTH));
  assign w_push    = bus.b_valid && w_b_ready && (bus.b_addr != 5'd0);
  assign w_pop     = !w_a_act && (r_count != 3'd0);

  // An entry survives unless it is the head being popped or A overwrites its register.
  always_comb begin
    w_keep = '0;
    w_kept = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i] = (3'(i) < r_count) && !(w_pop && (i == 0)) &&
                  !(w_a_act && (r_addr[i] == bus.a_addr));
      if (w_keep[i]) w_kept = w_kept + 3'd1;
    end
  end

  // Slot j takes the j-th surviving entry; the new push lands right after them.
  always_comb begin
    w_cnt = 3'd0;
    for (int j = 0; j < DEPTH; j++) begin
      w_addr[j] = r_addr[j];
      w_data[j] = r_data[j];
      w_pc[j]   = r_pc[j];
      w_cnt     = 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_keep[i]) begin
          if (w_cnt == 3'(j)) begin
            w_addr[j] = r_addr[i];
            w_data[j] = r_data[i];
            w_pc[j]   = r_pc[i];
          end
          w_cnt = w_cnt + 3'd1;
        end
      end
      if (w_push && (w_cnt == 3'(j))) begin
        w_addr[j] = bus.b_addr;
        w_data[j] = bus.b_data;
        w_pc[j]   = bus.b_pc;
      end
    end
  end

  assign w_count = w_kept + {2'd0, w_push};

  always_comb begin
    w_starve = r_starve;
    if (w_pop || (r_count == 3'd0))
      w_starve = '0;
    else if (w_a_act && (r_starve != c_STARVE_W'(STARVE_MAX)))
      w_starve = r_starve + 1'b1;
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (3'(i) < r_count) w_pend[r_addr[i]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_we  <= 1'b0;
      r_rf_a3  <= 5'd0;
      r_rf_wd  <= 32'd0;
      r_rf_pc  <= 32'd0;
      r_count  <= 3'd0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
        r_pc[i]   <= 32'd0;
      end
    end else begin
      if (w_a_act) begin
        r_rf_we <= 1'b1;
        r_rf_a3 <= bus.a_addr;
        r_rf_wd <= bus.a_data;
        r_rf_pc <= bus.a_pc;
      end else if (w_pop) begin
        r_rf_we <= 1'b1;
        r_rf_a3 <= r_addr[0];
        r_rf_wd <= r_data[0];
        r_rf_pc <= r_pc[0];
      end else begin
        r_rf_we <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= w_addr[i];
        r_data[i] <= w_data[i];
        r_pc[i]   <= w_pc[i];
      end
      r_count  <= w_count;
      r_starve <= w_starve;
      r_stall  <= (r_starve == c_STARVE_W'(STARVE_MAX));
    end
  end

  assign bus.b_ready   = w_b_ready;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_a3     = r_rf_a3;
  assign bus.rf_wd     = r_rf_wd;
  assign bus.rf_pc     = r_rf_pc;
  assign bus.pend_mask = w_pend;
  assign bus.a_stall   = r_stall;
  assign bus.b_count   = r_count;
endmodule
`default_nettype wire
